// File: rtl/hippo_lsu_if.sv
// hippo_lsu_if: width type plus the request/response/memory bundle between CPU, LSU and byte-lane memory
package hippo_lsu_pkg;
  typedef logic [1:0] mem_width_t;
  localparam mem_width_t BYTE = 2'd0;
  localparam mem_width_t HALFWORD = 2'd1;
  localparam mem_width_t WORD = 2'd2;
endpackage

interface hippo_lsu_if #(parameter int MEM_AW = 10);
  import hippo_lsu_pkg::*;
  logic req_valid_i, req_ready_o, req_we_i, req_sign_extend_i;
  mem_width_t req_width_i;
  logic [31:0] req_addr_i, req_data_i;
  logic rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic [MEM_AW-1:0] mem_addr_o;
  mem_width_t mem_width_o;
  logic mem_sign_extend_o, mem_we_o;
  logic [31:0] mem_data_o, mem_data_i;
  modport slave (
    input req_valid_i, req_we_i, req_width_i, req_sign_extend_i, req_addr_i, req_data_i, rsp_ready_i, mem_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, mem_addr_o, mem_width_o, mem_sign_extend_o, mem_data_o, mem_we_o
  );
  modport master (
    output req_valid_i, req_we_i, req_width_i, req_sign_extend_i, req_addr_i, req_data_i, rsp_ready_i, mem_data_i,
    input req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, mem_addr_o, mem_width_o, mem_sign_extend_o, mem_data_o, mem_we_o
  );
endinterface

// File: rtl/hippo_lsu.sv
// hippo_lsu: load/store unit in front of the byte-lane memory, one access per cycle with a one-deep response hold
// HIPPO_LSU_MISALIGN_TRAP_EN turns misaligned HALFWORD/WORD accesses into faults
module hippo_lsu
  import hippo_lsu_pkg::*;
#(
  parameter int MEMORY_DEPTH_BYTES = 1024
) (
  input logic clk_i,
  input logic rst_i,
  hippo_lsu_if.slave bus
);
  localparam int MemAddrWidth = $clog2(MEMORY_DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
  state_t state_q, state_d;
  logic we_q, fault_q, hold_err_q;
  logic [31:0] hold_data_q;
  logic [2:0] nbytes;
  logic [32:0] last;
  logic bad_width, range_fault, misalign, fault, fire;
  always_comb begin
    nbytes = bus.req_width_i == WORD ? 3'd4 : bus.req_width_i == HALFWORD ? 3'd2 : 3'd1;
    bad_width = bus.req_width_i == 2'd3;
    // 33 bits so addresses near 2^32 cannot wrap back into range
    last = {1'b0, bus.req_addr_i} + 33'(nbytes) - 33'd1;
    range_fault = last >= 33'(MEMORY_DEPTH_BYTES);
`ifdef HIPPO_LSU_MISALIGN_TRAP_EN
    misalign = (bus.req_width_i == HALFWORD && bus.req_addr_i[0]) ||
               (bus.req_width_i == WORD && bus.req_addr_i[1:0] != 2'd0);
`else
    misalign = 1'b0;
`endif
    fault = bad_width || range_fault || misalign;
    fire = bus.req_valid_i && bus.req_ready_o;
    state_d = bus.req_ready_o ? (fire ? PEND : IDLE) : HOLD;
  end
  assign bus.req_ready_o = state_q == IDLE || bus.rsp_ready_i;
  assign bus.rsp_valid_o = state_q != IDLE;
  assign bus.rsp_data_o = state_q == HOLD ? hold_data_q :
                          (state_q == PEND && !fault_q && !we_q) ? bus.mem_data_i : 32'd0;
  assign bus.rsp_err_o = state_q == HOLD ? hold_err_q : (state_q == PEND && fault_q);
  assign bus.mem_addr_o = bus.req_addr_i[MemAddrWidth-1:0];
  assign bus.mem_width_o = bus.req_width_i;
  assign bus.mem_sign_extend_o = bus.req_sign_extend_i;
  assign bus.mem_data_o = bus.req_data_i;
  assign bus.mem_we_o = fire && bus.req_we_i && !fault && !rst_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      fault_q <= 1'b0;
      hold_err_q <= 1'b0;
      hold_data_q <= 32'd0;
    end else begin
      if (fire) begin
        we_q <= bus.req_we_i;
        fault_q <= fault;
      end
      if (state_q == PEND && !bus.rsp_ready_i) begin
        hold_data_q <= bus.rsp_data_o;
        hold_err_q <= bus.rsp_err_o;
      end
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_hippo_lsu.sv
// tb_hippo_lsu: randomized and directed checks of hippo_lsu against a byte-array memory and response-queue model
module tb_hippo_lsu;
  import hippo_lsu_pkg::*;
  localparam int DEPTH = 1024;
  typedef struct {logic err; logic [31:0] data;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  hippo_lsu_if #(.MEM_AW(10)) bus();
  hippo_lsu #(.MEMORY_DEPTH_BYTES(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  function automatic logic [31:0] ext(input logic [1:0] w, input logic s, input logic [31:0] raw);
    if (w == BYTE) return s ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
    if (w == HALFWORD) return s ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
    return raw;
  endfunction

  function automatic bit model_fault(input logic [1:0] w, input logic [31:0] a);
    longint n = w == WORD ? 4 : w == HALFWORD ? 2 : 1;
    if (w == 2'd3) return 1'b1;
    if ({32'd0, a} + n - 1 >= DEPTH) return 1'b1;
`ifdef HIPPO_LSU_MISALIGN_TRAP_EN
    if ((w == HALFWORD && a[0]) || (w == WORD && a[1:0] != 2'd0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // memory: registered read of old contents, byte-lane write, any alignment
  logic [7:0] mem [DEPTH];
  bit mem_init;
  logic [31:0] rd;
  int ma, mn;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 37 + 5);
      mem_init <= 1'b1;
    end else begin
      ma = int'(bus.mem_addr_o);
      mn = bus.mem_width_o == WORD ? 4 : bus.mem_width_o == HALFWORD ? 2 : 1;
      rd <= ext(bus.mem_width_o, bus.mem_sign_extend_o,
                {mem[(ma + 3) % DEPTH], mem[(ma + 2) % DEPTH], mem[(ma + 1) % DEPTH], mem[ma]});
      if (bus.mem_we_o)
        for (int k = 0; k < mn; k++) mem[(ma + k) % DEPTH] <= bus.mem_data_o[8*k +: 8];
    end
  end
  assign bus.mem_data_i = rd;

  logic [7:0] shadow [DEPTH];
  rsp_t q[$];

  task automatic scoreboard_step();
    rsp_t r;
    bit fire, f;
    int a, n;
    fire = bus.req_valid_i && bus.req_ready_o;
    if (rst) begin
      q.delete();
      total++;
      if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL we_in_reset: got %b want 0", bus.mem_we_o); end
      return;
    end
    total++;
    if (bus.rsp_valid_o !== (q.size() != 0)) begin
      bad++; $display("FAIL rsp_valid: got %b want %b", bus.rsp_valid_o, q.size() != 0);
    end
    total++;
    if (bus.req_ready_o !== (q.size() == 0 || bus.rsp_ready_i)) begin
      bad++; $display("FAIL req_ready: got %b want %b", bus.req_ready_o, q.size() == 0 || bus.rsp_ready_i);
    end
    if (bus.rsp_valid_o === 1'b1 && q.size() != 0) begin
      total++;
      if ({bus.rsp_err_o, bus.rsp_data_o} !== {q[0].err, q[0].data}) begin
        bad++; $display("FAIL rsp: got err=%b data=%h want err=%b data=%h", bus.rsp_err_o, bus.rsp_data_o, q[0].err, q[0].data);
      end
      if (bus.rsp_ready_i) void'(q.pop_front());
    end
    f = model_fault(bus.req_width_i, bus.req_addr_i);
    total++;
    if (bus.mem_we_o !== (fire && bus.req_we_i && !f)) begin
      bad++; $display("FAIL mem_we: got %b want %b", bus.mem_we_o, fire && bus.req_we_i && !f);
    end
    total++;
    if (bus.mem_addr_o !== bus.req_addr_i[9:0] || bus.mem_data_o !== bus.req_data_i || bus.mem_width_o !== bus.req_width_i) begin
      bad++; $display("FAIL passthru: got addr=%h data=%h want addr=%h data=%h", bus.mem_addr_o, bus.mem_data_o, bus.req_addr_i[9:0], bus.req_data_i);
    end
    if (fire) begin
      r.err = f;
      r.data = 32'd0;
      a = int'(bus.req_addr_i[9:0]);
      n = bus.req_width_i == WORD ? 4 : bus.req_width_i == HALFWORD ? 2 : 1;
      if (!f && !bus.req_we_i)
        r.data = ext(bus.req_width_i, bus.req_sign_extend_i,
                     {shadow[(a + 3) % DEPTH], shadow[(a + 2) % DEPTH], shadow[(a + 1) % DEPTH], shadow[a]});
      if (!f && bus.req_we_i)
        for (int k = 0; k < n; k++) shadow[a + k] = bus.req_data_i[8*k +: 8];
      q.push_back(r);
    end
  endtask

  task automatic smp(); @(negedge clk); scoreboard_step(); endtask
  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic drive(input bit v, input bit we, input logic [1:0] w, input bit s, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid_i = v; bus.req_we_i = we; bus.req_width_i = w;
    bus.req_sign_extend_i = s; bus.req_addr_i = a; bus.req_data_i = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, WORD, 0, 0, 0);
    bus.rsp_ready_i = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    smp();
    total++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, bus.req_ready_o, bus.mem_we_o} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset: got v=%b e=%b d=%h rdy=%b we=%b want 0 0 0 1 0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, bus.req_ready_o, bus.mem_we_o);
    end
    cyc();
  endtask

  task automatic test_store_load();
    drive(1, 1, WORD, 0, 32'h10, 32'hDEADBEEF);
    smp();
    total++;
    if (bus.mem_we_o !== 1'b1) begin bad++; $display("FAIL store_we: got %b want 1", bus.mem_we_o); end
    cyc();
    drive(1, 0, WORD, 0, 32'h10, 0);
    smp();
    total++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o} !== {2'b10, 32'd0}) begin
      bad++; $display("FAIL store_rsp: got v=%b e=%b d=%h want 1 0 0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o);
    end
    cyc();
    drive(0, 0, WORD, 0, 0, 0);
    smp();
    total++;
    if ({bus.rsp_valid_o, bus.rsp_data_o} !== {1'b1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL load_rsp: got v=%b d=%h want 1 deadbeef", bus.rsp_valid_o, bus.rsp_data_o);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3] = '{32'd0, 32'hDEADBEEF, 32'h12345678};
    drive(1, 1, WORD, 0, 32'h14, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      smp();
      total++;
      if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.req_ready_o); end
      if (i > 0) begin
        total++;
        if ({bus.rsp_valid_o, bus.rsp_data_o} !== {1'b1, exp_d[i-1]}) begin
          bad++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want 1 %h", i, bus.rsp_valid_o, bus.rsp_data_o, exp_d[i-1]);
        end
      end
      cyc();
      if (i == 0) drive(1, 0, WORD, 0, 32'h10, 0);
      else if (i == 1) drive(1, 0, WORD, 0, 32'h14, 0);
      else drive(0, 0, WORD, 0, 0, 0);
    end
  endtask

  task automatic test_stall();
    bus.rsp_ready_i = 1'b0;
    drive(1, 0, WORD, 0, 32'h10, 0);
    smp(); cyc();
    drive(1, 1, WORD, 0, 32'h10, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      smp();
      total++;
      if ({bus.rsp_valid_o, bus.rsp_data_o, bus.req_ready_o, bus.mem_we_o} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
        bad++; $display("FAIL stall[%0d]: got v=%b d=%h rdy=%b we=%b want 1 deadbeef 0 0", i, bus.rsp_valid_o, bus.rsp_data_o, bus.req_ready_o, bus.mem_we_o);
      end
      cyc();
    end
    bus.rsp_ready_i = 1'b1;
    smp();
    total++;
    if ({bus.rsp_data_o, bus.req_ready_o, bus.mem_we_o} !== {32'hDEADBEEF, 2'b11}) begin
      bad++; $display("FAIL release: got d=%h rdy=%b we=%b want deadbeef 1 1", bus.rsp_data_o, bus.req_ready_o, bus.mem_we_o);
    end
    cyc();
    drive(1, 0, WORD, 0, 32'h10, 0);
    smp(); cyc();
    drive(0, 0, WORD, 0, 0, 0);
    smp();
    total++;
    if (bus.rsp_data_o !== 32'hCAFEF00D) begin bad++; $display("FAIL stall_store: got %h want cafef00d", bus.rsp_data_o); end
    cyc();
  endtask

  task automatic test_range_fault();
    logic [7:0] b0, b1;
    b0 = mem[1022]; b1 = mem[1023];
    drive(1, 1, WORD, 0, 32'h3FE, 32'h11223344);
    smp();
    total++;
    if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL fault_we: got %b want 0", bus.mem_we_o); end
    cyc();
    drive(0, 0, WORD, 0, 0, 0);
    smp();
    total++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o} !== {2'b11, 32'd0}) begin
      bad++; $display("FAIL fault_rsp: got v=%b e=%b d=%h want 1 1 0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o);
    end
    cyc();
    total++;
    if ({mem[1022], mem[1023]} !== {b0, b1}) begin
      bad++; $display("FAIL fault_mem: got %h%h want %h%h", mem[1022], mem[1023], b0, b1);
    end
  endtask

  task automatic test_misalign();
    drive(1, 1, WORD, 0, 32'h10, 32'h0080FF00);
    smp(); cyc();
    drive(1, 0, HALFWORD, 1, 32'h11, 0);
    smp(); cyc();
    drive(0, 0, WORD, 0, 0, 0);
    smp();
    total++;
`ifdef HIPPO_LSU_MISALIGN_TRAP_EN
    if ({bus.rsp_err_o, bus.rsp_data_o} !== {1'b1, 32'd0}) begin
      bad++; $display("FAIL misalign: got e=%b d=%h want 1 0", bus.rsp_err_o, bus.rsp_data_o);
    end
`else
    if ({bus.rsp_err_o, bus.rsp_data_o} !== {1'b0, 32'hFFFF80FF}) begin
      bad++; $display("FAIL misalign: got e=%b d=%h want 0 ffff80ff", bus.rsp_err_o, bus.rsp_data_o);
    end
`endif
    cyc();
  endtask

  task automatic test_reset_pend();
    logic [31:0] old;
    drive(1, 0, WORD, 0, 32'h20, 0);
    smp(); cyc();
    old = {mem[35], mem[34], mem[33], mem[32]};
    drive(1, 1, WORD, 0, 32'h20, 32'hA5A5A5A5);
    rst = 1'b1;
    smp();
    total++;
    if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus.mem_we_o); end
    cyc();
    rst = 1'b0;
    drive(0, 0, WORD, 0, 0, 0);
    smp();
    total++;
    if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin
      bad++; $display("FAIL rst_pend: got v=%b rdy=%b want 0 1", bus.rsp_valid_o, bus.req_ready_o);
    end
    cyc();
    total++;
    if ({mem[35], mem[34], mem[33], mem[32]} !== old) begin
      bad++; $display("FAIL rst_mem: got %h want %h", {mem[35], mem[34], mem[33], mem[32]}, old);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int sel, diff;
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 19));
      a = sel < 15 ? 32'($urandom_range(0, 63)) : sel < 19 ? 32'($urandom_range(1016, 1023)) : $urandom();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2)), $urandom_range(0, 1) != 0, a, $urandom());
      bus.rsp_ready_i = $urandom_range(0, 3) != 0;
      smp(); cyc();
    end
    drive(0, 0, WORD, 0, 0, 0);
    bus.rsp_ready_i = 1'b1;
    repeat (3) begin smp(); cyc(); end
    diff = -1;
    for (int i = 0; i < DEPTH; i++) if (diff < 0 && mem[i] !== shadow[i]) diff = i;
    total++;
    if (diff >= 0) begin bad++; $display("FAIL mem_image: byte %0d got %h want %h", diff, mem[diff], shadow[diff]); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = 8'(i * 37 + 5);
    #1;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_stall();
    test_range_fault();
    test_misalign();
    test_reset_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hippo_lsu.md
Name: hippo_lsu

Overview:
Load/store unit directly upstream of the interleaved byte-lane data memory. Accepts CPU load/store requests over a valid/ready handshake and drives the memory port (addr, width, sign-extend, data, write enable). Captures the memory's registered one-cycle-latency read data and returns it on a valid/ready response channel. Sustains one access per cycle and buffers the response when the consumer stalls.

Parameters:
MEMORY_DEPTH_BYTES, 1024, byte size of the attached memory; sets the range check and the memory address width.
MemAddrWidth (localparam), $clog2(MEMORY_DEPTH_BYTES), width of mem_addr_o.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_we_i  in  1  1 = store, 0 = load
req_width_i  in  mem_width_t  BYTE / HALFWORD / WORD
req_sign_extend_i  in  1  sign-extend load result
req_addr_i  in  32  byte address
req_data_i  in  32  store data, LSB-aligned
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_data_o  out  32  load data (0 for stores and errors)
rsp_err_o  out  1  access fault
mem_addr_o  out  MemAddrWidth  to memory addr_i
mem_width_o  out  mem_width_t  to memory width_i
mem_sign_extend_o  out  1  to memory sign_extend_i
mem_data_o  out  32  to memory data_i
mem_we_o  out  1  to memory write_enable_i
mem_data_i  in  32  from memory data_o (valid one cycle after address)

Behaviour:
- Reset: clock is clk_i; reset is synchronous, active-high on rst_i. On reset: state=IDLE, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, hold register=0, mem_we_o=0.
- mem_addr_o, mem_width_o, mem_sign_extend_o and mem_data_o pass req_* through combinationally every cycle. mem_addr_o = req_addr_i[MemAddrWidth-1:0].
- fire = req_valid_i && req_ready_o. mem_we_o = fire && req_we_i && !fault && !rst_i.
- fault = req_addr_i + bytes(width) - 1 >= MEMORY_DEPTH_BYTES, or width is not BYTE/HALFWORD/WORD. A faulting access never writes memory.
- States:
  - IDLE: no response outstanding. req_ready_o=1. fire -> PEND.
  - PEND: response for the access fired last cycle. rsp_valid_o=1. rsp_data_o = registered-fault ? 0 : (registered-we ? 0 : mem_data_i). rsp_err_o = registered fault.
    - rsp_ready_i=1: req_ready_o=1. fire -> PEND, else -> IDLE.
    - rsp_ready_i=0: req_ready_o=0. Capture data/err into the hold register; -> HOLD.
  - HOLD: rsp_valid_o=1, outputs from the hold register; mem_data_i is ignored. req_ready_o=rsp_ready_i.
    - rsp_ready_i=1 and fire -> PEND.
    - rsp_ready_i=1, no fire -> IDLE.
    - rsp_ready_i=0 -> stay in HOLD.
- Per-fire sideband (we, fault) is registered in the fire cycle. Read latency is exactly 1 cycle when rsp_ready_i is high. Peak throughput is 1 access/cycle.
- Response order equals request order. At most one response is outstanding.
- Sign/zero extension is done by the memory. The LSU does not alter mem_data_i.
- Reset mid-operation: the outstanding response is dropped and is not presented after reset. A store firing in the same cycle as rst_i is suppressed.
- Stores to an address read in the preceding cycle: the load response reflects the old data; the memory's write-after-read ordering is preserved.

Optional Feature:
HIPPO_LSU_MISALIGN_TRAP_EN
- Defined: a HALFWORD access with addr[0]!=0, or a WORD access with addr[1:0]!=0, is a fault: rsp_err_o=1, rsp_data_o=0, no write.
- Undefined: misaligned accesses pass through to the interleaved memory, which serves them natively. Only the range fault applies.

Test Plan:
- Reset, then WORD store 0xDEADBEEF @0x10 -> response in next cycle with err=0, data=0. WORD load @0x10 -> rsp_data_o=0xDEADBEEF exactly one cycle after fire.
- Back-to-back loads @0x10, @0x14 with rsp_ready_i=1 -> req_ready_o stays 1. Responses arrive on consecutive cycles in order.
- Load @0x10 with rsp_ready_i=0 for 3 cycles -> HOLD keeps rsp_data_o=0xDEADBEEF and req_ready_o=0. Store @0x10 from another requester is not accepted until the stall releases.
- WORD store @0x3FE (depth 1024) -> rsp_err_o=1, mem_we_o never asserted, memory unchanged.
- HALFWORD signed load @0x11 after storing 0x0080FF00 @0x10:
  - macro undefined -> rsp_data_o=0xFFFF80FF.
  - macro defined -> rsp_err_o=1, rsp_data_o=0.
- Assert rst_i in PEND with a store presented -> no write occurs, rsp_valid_o=0 next cycle, state IDLE.
